// File: rtl/fp_pkg.sv
// Shared floating-point constants, accumulator FSM states and a
// leading-zero counter used by the adder's normalisation step.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [FP_WIDTH-1:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Number of leading zeros in a 27-bit value; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/floating_unit.sv
// Combinational IEEE-754 binary32 adder/subtractor, round-to-nearest-even.
// Handles denormals, infinities and NaNs; exact cancellation gives +0.
module floating_unit
  import fp_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  input  logic                op,
  output logic [FP_WIDTH-1:0] result
);

  localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP_WIDTH-1:0] QBIT = 32'h0040_0000;

  logic             sa, sb, sx, sy, sub, rs, swap;
  logic             a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ex_f, ey_f;
  logic [MAN_W-1:0] fx, fy;
  logic [9:0]       ex, ey, d, e, sh;
  logic [23:0]      mx, my;
  logic [26:0]      ylong, yal;
  logic [27:0]      x;
  logic [4:0]       lz;
  logic             rnd;
  logic [24:0]      m;
  logic [9:0]       ef;

  // Align, add/subtract, normalise, round, then override with special cases.
  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ op;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);

    // Larger magnitude becomes x so the subtraction never goes negative.
    swap = b[30:0] > a[30:0];
    if (swap) begin
      sx = sb; ex_f = b[30:23]; fx = b[22:0];
      sy = sa; ey_f = a[30:23]; fy = a[22:0];
    end else begin
      sx = sa; ex_f = a[30:23]; fx = a[22:0];
      sy = sb; ey_f = b[30:23]; fy = b[22:0];
    end
    ex  = (ex_f == '0) ? 10'd1 : {2'b00, ex_f};
    ey  = (ey_f == '0) ? 10'd1 : {2'b00, ey_f};
    mx  = {|ex_f, fx};
    my  = {|ey_f, fy};
    d   = ex - ey;
    sub = sx ^ sy;

    // Guard, round and sticky bits sit below the mantissa.
    ylong = {my, 3'b000};
    if (d >= 10'd27) begin
      yal = {26'b0, |my};
    end else begin
      yal = (ylong >> d) | {26'b0, |(ylong & ~({27{1'b1}} << d))};
    end

    if (sub) x = {1'b0, mx, 3'b000} - {1'b0, yal};
    else     x = {1'b0, mx, 3'b000} + {1'b0, yal};

    e  = ex;
    lz = 5'd0;
    sh = 10'd0;
    if (x[27]) begin
      x = {1'b0, x[27:2], x[1] | x[0]};
      e = e + 10'd1;
    end else begin
      // Left shift stops at exponent 1 so small results become denormal.
      lz = lzc27(x[26:0]);
      sh = ({5'b0, lz} < (e - 10'd1)) ? {5'b0, lz} : (e - 10'd1);
      x  = x << sh;
      e  = e - sh;
    end

    rnd = x[2] & (x[1] | x[0] | x[3]);
    m   = {1'b0, x[26:3]} + {24'b0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    ef = m[23] ? e : 10'd0;
    rs = (sub && (m == '0)) ? 1'b0 : sx;

    if (e >= 10'd255) result = {sx, 8'hFF, 23'b0};
    else              result = {rs, ef[7:0], m[22:0]};

    if (a_nan)                            result = a | QBIT;
    else if (b_nan)                       result = b | QBIT;
    else if (a_inf && b_inf && (sa != sb)) result = QNAN;
    else if (a_inf)                       result = {sa, 8'hFF, 23'b0};
    else if (b_inf)                       result = {sb, 8'hFF, 23'b0};
  end

endmodule

// File: rtl/fp_stream_accumulator.sv
// Packet-wise floating-point accumulator. Operands arrive on a valid/ready
// stream; the registered running sum and beat count are presented on a
// valid/ready output once the last beat of a packet has been added.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends combinationally on ready, and ready here
// depends only on the FSM state.
module fp_stream_accumulator
  import fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  acc_state_t       state, state_nx;
  logic [WIDTH-1:0] acc, add_res;
  logic [CNT_W-1:0] count;
  logic             sat, first, accept;

  floating_unit u_add (
    .a      (acc),
    .b      (in_data),
    .op     (OP_ADD),
    .result (add_res)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  assign out_sum   = acc;
  assign out_count = count;
  assign out_sat   = sat;

  // Next-state: leave ACCUM on the last beat, leave HOLD on output handoff.
  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nx = HOLD;
      HOLD:    if (out_ready)         state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // State, running sum and saturating beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= POS_ZERO;
      count <= '0;
      sat   <= 1'b0;
      first <= 1'b1;
    end else begin
      state <= state_nx;
      if (out_valid && out_ready) begin
        acc   <= POS_ZERO;
        count <= '0;
        sat   <= 1'b0;
        first <= 1'b1;
      end else if (accept) begin
        // First beat is loaded verbatim so -0 and NaN payloads survive.
        acc   <= first ? in_data : add_res;
        first <= 1'b0;
        if (&count) sat   <= 1'b1;
        else        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Self-checking bench: two accumulators (8-bit and 2-bit counters) share one
// input stream; a scoreboard holds expected sums/counts per packet.
module tb_fp_stream_accumulator;

  localparam int SB_W = 44;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [31:0] out_sum_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [31:0] out_sum_b;
  logic [1:0]  out_count_b;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  logic [SB_W-1:0] exp_q[$];
  logic [31:0]     pkt[0:15];

  fp_stream_accumulator #(.WIDTH(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_sat(out_sat_a)
  );

  fp_stream_accumulator #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_sat(out_sat_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input int unsigned v);
    int          p;
    logic [31:0] mant;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    mant = v << (23 - p);
    return {1'b0, 8'(127 + p), mant[22:0]};
  endfunction

  task automatic push_exp(input logic [31:0] sum, input int n);
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = (n > 255) ? 8'hFF : 8'(n);
    c2 = (n > 3) ? 2'd3 : 2'(n);
    exp_q.push_back({sum, c8, (n > 255), c2, (n > 3)});
  endtask

  // out_ready changes just after the rising edge, never at the sampling edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: compare on every output handoff.
  initial begin
    logic [SB_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_a && out_ready) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sum_a",   out_sum_a,   e[43:12]);
          chk("count_a", out_count_a, e[11:4]);
          chk("sat_a",   out_sat_a,   e[3]);
          chk("valid_b", out_valid_b, 1);
          chk("sum_b",   out_sum_b,   e[43:12]);
          chk("count_b", out_count_b, e[2:1]);
          chk("sat_b",   out_sat_b,   e[0]);
        end
      end
    end
  end

  // Drive one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (!in_ready_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("accept_timeout", t, 0);
    chk("in_ready_b", in_ready_b, 1);
    @(negedge clk);
  endtask

  task automatic send_pkt(input int n, input logic [31:0] sum, input string tag);
    push_exp(sum, n);
    for (int i = 0; i < n; i++) drive_beat(pkt[i], (i == n - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_lat_valid"}, out_valid_a, 1);
    chk({tag, "_lat_sum"},   out_sum_a,   sum);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid_a) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int t, n;
    int unsigned v, tot;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  in_ready_a,  1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_sum",       out_sum_a,   0);
    chk("rst_count",     out_count_a, 0);
    chk("rst_sat",       out_sat_a,   0);
    @(negedge clk);

    pkt[0] = 32'h3E8C0001;
    send_pkt(1, 32'h3E8C0001, "single");
    pkt[0] = 32'h3FFFFFFF; pkt[1] = 32'h3FFFFFFF;
    send_pkt(2, 32'h407FFFFF, "double");
    pkt[0] = 32'hBFFFFFFF; pkt[1] = 32'h3FFFFFFF;
    send_pkt(2, 32'h00000000, "cancel");
    pkt[0] = 32'h3FFFFFFF; pkt[1] = 32'h3FFFFFFF; pkt[2] = 32'hBFFFFFFF;
    send_pkt(3, 32'h3FFFFFFF, "three");
    pkt[0] = 32'h000002CA; pkt[1] = 32'h000002CA;
    send_pkt(2, 32'h00000594, "denorm");
    pkt[0] = 32'h7F800000; pkt[1] = 32'h42F60000;
    send_pkt(2, 32'h7F800000, "inf");
    pkt[0] = 32'h80000000;
    send_pkt(1, 32'h80000000, "negzero");
    pkt[0] = 32'h3F800000; pkt[1] = 32'h7FC00000;
    send_pkt(2, 32'h7FC00000, "nan");
    for (int i = 0; i < 5; i++) pkt[i] = 32'h0;
    send_pkt(5, 32'h00000000, "sat");
    drain("basic");

    // Backpressure: sum held while out_ready is low and a beat is waiting.
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    pkt[0] = 32'h3F800000; pkt[1] = 32'h40000000;
    send_pkt(2, 32'h40400000, "bp");
    push_exp(32'h3F800000, 1);
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready",   in_ready_a,  0);
      chk("bp_in_ready_b", in_ready_b,  0);
      chk("bp_valid",      out_valid_a, 1);
      chk("bp_sum",        out_sum_a,   32'h40400000);
      @(negedge clk);
    end
    rdy_mode = 0;
    t = 0;
    while (!out_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("bp_bubble_ready", in_ready_a,  1);
    chk("bp_bubble_valid", out_valid_a, 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", out_valid_a, 1);
    chk("bp_next_sum",   out_sum_a,   32'h3F800000);
    drain("bp");

    // Reset mid-packet discards the partial sum.
    drive_beat(32'h3F800000, 1'b0);
    drive_beat(32'h40000000, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", out_valid_a, 0);
    chk("mrst_count", out_count_a, 0);
    chk("mrst_ready", in_ready_a,  1);
    @(negedge clk);
    chk("mrst_valid2", out_valid_a, 0);
    pkt[0] = 32'h40000000;
    send_pkt(1, 32'h40000000, "after_rst");
    drain("rst");

    // Random integer-valued packets with random downstream stalls.
    rdy_mode = 2;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 6);
      tot = 0;
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(0, 1000);
        pkt[i] = i2f(v);
        tot += v;
      end
      send_pkt(n, i2f(tot), "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_mode = 0;
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
